imem_loader: RTL

- Writer side of the instruction SRAM. The fetch path only ever reads that SRAM with we=0; this block is the only agent that writes it.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words, first byte most significant.
- Writes the words to consecutive word addresses starting at BASE_ADDR.
- Holds the CPU in stall while loading and pulses done when the program is in place.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 119 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction SRAM loader: FSM state encoding and
// packing geometry.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_STRIDE    = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus SRAM write/readback bus of the instruction loader.
// The loader side uses the master modport, the stream source and SRAM use slave.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;

    modport master (
        input  byte_valid, byte_data, sram_dout,
        output byte_ready, sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );

    modport slave (
        output byte_valid, byte_data, sram_dout,
        input  byte_ready, sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes into a 32-bit word, first byte ending up most significant.
// full flags the accept that completes a word, so the caller can act on that edge.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [BYTE_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (accept) begin
            word  <= {word[23:0], data_byte};
            count <= count + BYTE_CNT_W'(1);
        end
    end

    assign full = accept && (count == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction SRAM loader: packs a byte stream into words, writes them from BASE_ADDR
// upward and stalls the CPU meanwhile. Define IMEM_LOADER_READBACK_EN to verify each write.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   word_count,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            state, next_state;
    logic [15:0]       n_words;
    logic [15:0]       index;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [31:0]       packed_word;
    logic [7:0]        unused_top_byte;
    logic              accept, full, start_ok, last_word, advance;

    assign accept          = bus.byte_valid && (state == ST_COLLECT);
    assign start_ok        = start && (state == ST_IDLE);
    assign last_word       = ({1'b0, index} + 17'd1) == {1'b0, n_words};
    assign unused_top_byte = packed_word[31:24];

`ifdef IMEM_LOADER_READBACK_EN
    assign advance = (state == ST_CHECK);
`else
    assign advance = (state == ST_WRITE);
    logic unused_dout;
    assign unused_dout = ^bus.sram_dout;
`endif

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept),
        .clear     (start_ok),
        .data_byte (bus.byte_data),
        .word      (packed_word),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == 16'd0 || {1'b0, word_count} > MAX_N)
                        next_state = ST_DONE;
                    else
                        next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: if (full) next_state = ST_WRITE;
`ifdef IMEM_LOADER_READBACK_EN
            ST_WRITE:   next_state = ST_CHECK;
            ST_CHECK:   next_state = last_word ? ST_DONE : ST_COLLECT;
`else
            ST_WRITE:   next_state = last_word ? ST_DONE : ST_COLLECT;
`endif
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Address and data are registered on the edge that completes a word so they
    // stay stable through WRITE/CHECK and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words <= '0;
            index   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            err     <= 1'b0;
        end else begin
            if (start_ok) begin
                n_words <= word_count;
                index   <= '0;
                err     <= ({1'b0, word_count} > MAX_N);
            end
            if (full) begin
                din_q  <= {packed_word[23:0], bus.byte_data};
                addr_q <= BASE_ADDR + ADDR_W'(index) * ADDR_W'(WORD_STRIDE);
            end
            if (advance) index <= index + 16'd1;
`ifdef IMEM_LOADER_READBACK_EN
            if (state == ST_CHECK && bus.sram_dout != din_q) err <= 1'b1;
`endif
        end
    end

    assign bus.byte_ready = (state == ST_COLLECT);
    assign bus.sram_cs    = (state == ST_WRITE) || (state == ST_CHECK);
    assign bus.sram_we    = (state == ST_WRITE);
    assign bus.sram_oe    = (state == ST_CHECK);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_din   = din_q;
    assign busy           = (state == ST_COLLECT) || (state == ST_WRITE) || (state == ST_CHECK);
    assign cpu_hold       = busy;
    assign done           = (state == ST_DONE);

endmodule
